reg_scoreboard: RTL and testbench
=================================

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL provide: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL provide: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL provide: issue_valid  input  1  ID has issued an instruction that writes a register.
REQ-004 SHALL provide: issue_waddr  input  5  destination register of the issued instruction.
REQ-005 SHALL provide: issue_is_load  input  1  issued instruction's result comes from memory.
REQ-006 SHALL provide: wb_valid  input  1  writeback stage commits a register write.
REQ-007 SHALL provide: wb_waddr  input  5  register being written back.
REQ-008 SHALL provide: flush  input  1  pipeline flush; discards all in-flight tracking.
REQ-009 SHALL provide: query_valid  input  1  ID holds a real instruction (not bubble/NOP).
REQ-010 SHALL provide: reg1_raddr, reg2_raddr  input  5 each  source registers being decoded.
REQ-011 SHALL provide: stall_id  output  1  a source register has an outstanding write.
REQ-012 SHALL provide: stall_mem  output  1  a source register has an outstanding load write.
REQ-013 SHALL provide: issue_full  output  1  issue_waddr's counter is saturated; ID must hold.
REQ-014 SHALL provide: err_ovf, err_unf  output  1 each  sticky overflow/underflow flags.

Function
REQ-015 SHALL hold per register 1..31 a 2-bit in-flight count cnt[r] (0..3) and a load flag ld[r]; register 0 SHALL never be tracked (issue/wb to x0 ignored, queries of x0 never stall).
REQ-016 SHALL, on issue_valid with wb not targeting the same register, increment cnt[issue_waddr] at the next edge.
REQ-017 SHALL, on wb_valid with issue not targeting the same register, decrement cnt[wb_waddr] at the next edge.
REQ-018 SHALL leave cnt unchanged when issue_valid and wb_valid target the same register in one cycle.
REQ-019 SHALL set ld[issue_waddr] when issue_is_load is high with an accepted issue; SHALL clear ld[r] in the cycle cnt[r] becomes 0.
REQ-020 SHALL ignore an issue when cnt[issue_waddr]==3 (count saturates) and set err_ovf.
REQ-021 SHALL ignore a wb when cnt[wb_waddr]==0 and set err_unf.
REQ-022 SHALL drive issue_full combinationally = (cnt[issue_waddr]==3) and issue_waddr!=0, independent of issue_valid.
REQ-023 SHALL drive stall_id combinationally = query_valid and (cnt[reg1_raddr]!=0 or cnt[reg2_raddr]!=0), x0 excluded.
REQ-024 SHALL drive stall_mem combinationally = stall_id and ld of the matching pending source register set.
REQ-025 SHALL base stalls on registered state only: an issue in cycle N affects stall_id from N+1; a wb in cycle N releases stall_id from N+1 (no same-cycle bypass).
REQ-026 SHALL, on flush, clear every cnt and ld at the next edge; flush SHALL override issue and wb in the same cycle; err flags SHALL be unaffected by flush.
REQ-027 SHALL treat reg1_raddr==reg2_raddr identically to a single source.

Reset
REQ-028 SHALL, with rst_n low at a rising edge, clear all cnt, ld, err_ovf, err_unf; stall_id, stall_mem, issue_full SHALL read 0 from the following cycle.
REQ-029 SHALL give rst_n priority over flush, issue and wb; reset mid-operation SHALL discard all in-flight state.
REQ-030 SHALL clear err_ovf/err_unf only by reset.

Verification
REQ-031 Issue x5 (non-load) cycle 0, query reg1=5 cycle 1 -> stall_id=1, stall_mem=0; wb x5 cycle 2 -> stall_id=0 cycle 3.
REQ-032 Issue x7 load cycle 0, query reg2=7 -> stall_id=1, stall_mem=1 from cycle 1; wb x7 -> both 0 next cycle.
REQ-033 Issue x3 three times -> issue_full=1 with issue_waddr=3; fourth issue -> cnt stays 3, err_ovf=1; three wb x3 -> stall releases only after third.
REQ-034 Same-cycle issue x9 and wb x9 with cnt[9]=1 -> cnt stays 1, stall_id remains 1; wb x4 with cnt[4]=0 -> err_unf=1.
REQ-035 Issue x0, query reg1=0 -> stall_id=0; query_valid=0 with pending x5 -> stall_id=0.
REQ-036 Pending x5,x6 then flush concurrent with issue x8 -> all stalls 0 next cycle, cnt[8]=0; rst_n low -> err flags cleared.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Register write scoreboard: tracks in-flight writes per architectural register and
// raises decode stalls when a source operand still has an outstanding write.
module reg_scoreboard (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       issue_valid,
   input  logic [4:0] issue_waddr,
   input  logic       issue_is_load,
   input  logic       wb_valid,
   input  logic [4:0] wb_waddr,
   input  logic       flush,
   input  logic       query_valid,
   input  logic [4:0] reg1_raddr,
   input  logic [4:0] reg2_raddr,
   output logic       stall_id,
   output logic       stall_mem,
   output logic       issue_full,
   output logic       err_ovf,
   output logic       err_unf
);

   logic [31:0][1:0] cnt_q, cnt_d;
   logic [31:0]      ld_q, ld_d;
   logic             err_ovf_q, err_ovf_d;
   logic             err_unf_q, err_unf_d;

   logic same_reg;
   logic issue_live;
   logic wb_live;
   logic pend1, pend2;

   // An issue and a writeback to the same register cancel out in that cycle.
   assign same_reg   = issue_valid && wb_valid && (issue_waddr == wb_waddr);
   assign issue_live = issue_valid && (issue_waddr != 5'd0) && !same_reg;
   assign wb_live    = wb_valid && (wb_waddr != 5'd0) && !same_reg;

   always_comb begin
      cnt_d     = cnt_q;
      ld_d      = ld_q;
      err_ovf_d = err_ovf_q;
      err_unf_d = err_unf_q;
      if (flush) begin
         cnt_d = '0;
         ld_d  = '0;
      end else begin
         if (issue_live) begin
            if (cnt_q[issue_waddr] == 2'd3) begin
               err_ovf_d = 1'b1;
            end else begin
               cnt_d[issue_waddr] = cnt_q[issue_waddr] + 2'd1;
               if (issue_is_load) begin
                  ld_d[issue_waddr] = 1'b1;
               end
            end
         end
         // issue_live and wb_live never share an address, so these writes are disjoint.
         if (wb_live) begin
            if (cnt_q[wb_waddr] == 2'd0) begin
               err_unf_d = 1'b1;
            end else begin
               cnt_d[wb_waddr] = cnt_q[wb_waddr] - 2'd1;
               if (cnt_q[wb_waddr] == 2'd1) begin
                  ld_d[wb_waddr] = 1'b0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         ld_q      <= '0;
         err_ovf_q <= 1'b0;
         err_unf_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         ld_q      <= ld_d;
         err_ovf_q <= err_ovf_d;
         err_unf_q <= err_unf_d;
      end
   end

   assign pend1 = (reg1_raddr != 5'd0) && (cnt_q[reg1_raddr] != 2'd0);
   assign pend2 = (reg2_raddr != 5'd0) && (cnt_q[reg2_raddr] != 2'd0);

   assign stall_id   = query_valid && (pend1 || pend2);
   assign stall_mem  = query_valid && ((pend1 && ld_q[reg1_raddr]) ||
                                       (pend2 && ld_q[reg2_raddr]));
   assign issue_full = (issue_waddr != 5'd0) && (cnt_q[issue_waddr] == 2'd3);
   assign err_ovf    = err_ovf_q;
   assign err_unf    = err_unf_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus randomized traffic
// compared against a per-register count/flag model.
module tb_reg_scoreboard;

   logic       clk;
   logic       rst_n;
   logic       issue_valid;
   logic [4:0] issue_waddr;
   logic       issue_is_load;
   logic       wb_valid;
   logic [4:0] wb_waddr;
   logic       flush;
   logic       query_valid;
   logic [4:0] reg1_raddr;
   logic [4:0] reg2_raddr;
   logic       stall_id;
   logic       stall_mem;
   logic       issue_full;
   logic       err_ovf;
   logic       err_unf;

   int total = 0;
   int bad   = 0;

   int m_cnt[32];
   bit m_ld[32];
   bit m_ovf;
   bit m_unf;

   reg_scoreboard dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .issue_valid  (issue_valid),
      .issue_waddr  (issue_waddr),
      .issue_is_load(issue_is_load),
      .wb_valid     (wb_valid),
      .wb_waddr     (wb_waddr),
      .flush        (flush),
      .query_valid  (query_valid),
      .reg1_raddr   (reg1_raddr),
      .reg2_raddr   (reg2_raddr),
      .stall_id     (stall_id),
      .stall_mem    (stall_mem),
      .issue_full   (issue_full),
      .err_ovf      (err_ovf),
      .err_unf      (err_unf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: apply the current inputs as one clock edge would.
   task automatic model_edge();
      bit same;
      int a;
      int b;
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            m_cnt[i] = 0;
            m_ld[i]  = 0;
         end
         m_ovf = 0;
         m_unf = 0;
      end else if (flush) begin
         for (int i = 0; i < 32; i++) begin
            m_cnt[i] = 0;
            m_ld[i]  = 0;
         end
      end else begin
         a = int'(issue_waddr);
         b = int'(wb_waddr);
         same = issue_valid && wb_valid && (a == b);
         if (issue_valid && a != 0 && !same) begin
            if (m_cnt[a] == 3) m_ovf = 1;
            else begin
               m_cnt[a] = m_cnt[a] + 1;
               if (issue_is_load) m_ld[a] = 1;
            end
         end
         if (wb_valid && b != 0 && !same) begin
            if (m_cnt[b] == 0) m_unf = 1;
            else begin
               m_cnt[b] = m_cnt[b] - 1;
               if (m_cnt[b] == 0) m_ld[b] = 0;
            end
         end
      end
   endtask

   function automatic bit pend(input logic [4:0] r);
      return (r != 5'd0) && (m_cnt[int'(r)] > 0);
   endfunction

   function automatic bit exp_stall_id();
      return query_valid && (pend(reg1_raddr) || pend(reg2_raddr));
   endfunction

   function automatic bit exp_stall_mem();
      return query_valid && ((pend(reg1_raddr) && m_ld[int'(reg1_raddr)]) ||
                             (pend(reg2_raddr) && m_ld[int'(reg2_raddr)]));
   endfunction

   function automatic bit exp_full();
      return (issue_waddr != 5'd0) && (m_cnt[int'(issue_waddr)] == 3);
   endfunction

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst_n         = 1'b1;
      issue_valid   = 1'b0;
      issue_waddr   = 5'd0;
      issue_is_load = 1'b0;
      wb_valid      = 1'b0;
      wb_waddr      = 5'd0;
      flush         = 1'b0;
      query_valid   = 1'b0;
      reg1_raddr    = 5'd0;
      reg2_raddr    = 5'd0;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      idle();
      issue_valid = 1'b1; issue_waddr = 5'd5; issue_is_load = 1'b1;
      tick();
      issue_valid = 1'b1; issue_waddr = 5'd0; wb_valid = 1'b1; wb_waddr = 5'd9;
      tick();
      do_reset();
      issue_waddr = 5'd5; query_valid = 1'b1; reg1_raddr = 5'd5; reg2_raddr = 5'd9;
      #1;
      total++;
      if (stall_id !== 1'b0) begin
         bad++; $display("FAIL reset_stall_id got=%b want=0", stall_id);
      end
      total++;
      if (stall_mem !== 1'b0) begin
         bad++; $display("FAIL reset_stall_mem got=%b want=0", stall_mem);
      end
      total++;
      if (issue_full !== 1'b0) begin
         bad++; $display("FAIL reset_issue_full got=%b want=0", issue_full);
      end
      total++;
      if (err_ovf !== 1'b0 || err_unf !== 1'b0) begin
         bad++; $display("FAIL reset_err got=%b%b want=00", err_ovf, err_unf);
      end
   endtask

   task automatic test_basic();
      do_reset();
      issue_valid = 1'b1; issue_waddr = 5'd5;
      tick();
      idle(); query_valid = 1'b1; reg1_raddr = 5'd5; reg2_raddr = 5'd1;
      #1;
      total++;
      if (stall_id !== 1'b1 || stall_mem !== 1'b0) begin
         bad++; $display("FAIL basic_pending got=%b%b want=10", stall_id, stall_mem);
      end
      wb_valid = 1'b1; wb_waddr = 5'd5;
      #1;
      total++;
      if (stall_id !== 1'b1) begin
         bad++; $display("FAIL basic_no_bypass got=%b want=1", stall_id);
      end
      tick();
      wb_valid = 1'b0;
      #1;
      total++;
      if (stall_id !== 1'b0) begin
         bad++; $display("FAIL basic_release got=%b want=0", stall_id);
      end
   endtask

   task automatic test_load();
      do_reset();
      issue_valid = 1'b1; issue_waddr = 5'd7; issue_is_load = 1'b1;
      query_valid = 1'b1; reg2_raddr = 5'd7;
      #1;
      total++;
      if (stall_id !== 1'b0) begin
         bad++; $display("FAIL load_same_cycle got=%b want=0", stall_id);
      end
      tick();
      issue_valid = 1'b0; issue_is_load = 1'b0;
      #1;
      total++;
      if (stall_id !== 1'b1 || stall_mem !== 1'b1) begin
         bad++; $display("FAIL load_pending got=%b%b want=11", stall_id, stall_mem);
      end
      wb_valid = 1'b1; wb_waddr = 5'd7;
      tick();
      wb_valid = 1'b0;
      #1;
      total++;
      if (stall_id !== 1'b0 || stall_mem !== 1'b0) begin
         bad++; $display("FAIL load_release got=%b%b want=00", stall_id, stall_mem);
      end
   endtask

   task automatic test_saturate();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         issue_valid = 1'b1; issue_waddr = 5'd3;
         tick();
      end
      issue_valid = 1'b0;
      #1;
      total++;
      if (issue_full !== 1'b1) begin
         bad++; $display("FAIL sat_full got=%b want=1", issue_full);
      end
      issue_valid = 1'b1;
      tick();
      issue_valid = 1'b0;
      #1;
      total++;
      if (err_ovf !== 1'b1 || issue_full !== 1'b1) begin
         bad++; $display("FAIL sat_ovf got=%b%b want=11", err_ovf, issue_full);
      end
      query_valid = 1'b1; reg1_raddr = 5'd3;
      for (int i = 0; i < 3; i++) begin
         wb_valid = 1'b1; wb_waddr = 5'd3;
         tick();
         wb_valid = 1'b0;
         #1;
         total++;
         if (stall_id !== (i == 2 ? 1'b0 : 1'b1)) begin
            bad++; $display("FAIL sat_drain%0d got=%b want=%b", i, stall_id, i != 2);
         end
      end
   endtask

   task automatic test_same_cycle();
      do_reset();
      issue_valid = 1'b1; issue_waddr = 5'd9;
      tick();
      wb_valid = 1'b1; wb_waddr = 5'd9;
      tick();
      idle(); query_valid = 1'b1; reg1_raddr = 5'd9; reg2_raddr = 5'd9;
      #1;
      total++;
      if (stall_id !== 1'b1 || err_unf !== 1'b0 || err_ovf !== 1'b0) begin
         bad++; $display("FAIL same_cycle got=%b%b%b want=100", stall_id, err_unf, err_ovf);
      end
      wb_valid = 1'b1; wb_waddr = 5'd9;
      tick();
      wb_waddr = 5'd4;
      tick();
      wb_valid = 1'b0;
      #1;
      total++;
      if (stall_id !== 1'b0 || err_unf !== 1'b1) begin
         bad++; $display("FAIL underflow got=%b%b want=01", stall_id, err_unf);
      end
   endtask

   task automatic test_x0();
      do_reset();
      issue_valid = 1'b1; issue_waddr = 5'd0;
      tick();
      issue_valid = 1'b1; issue_waddr = 5'd5;
      tick();
      issue_valid = 1'b0; issue_waddr = 5'd0;
      query_valid = 1'b1; reg1_raddr = 5'd0; reg2_raddr = 5'd0;
      #1;
      total++;
      if (stall_id !== 1'b0 || issue_full !== 1'b0) begin
         bad++; $display("FAIL x0_query got=%b%b want=00", stall_id, issue_full);
      end
      query_valid = 1'b0; reg1_raddr = 5'd5;
      #1;
      total++;
      if (stall_id !== 1'b0) begin
         bad++; $display("FAIL no_query got=%b want=0", stall_id);
      end
   endtask

   task automatic test_flush();
      do_reset();
      wb_valid = 1'b1; wb_waddr = 5'd12;
      tick();
      issue_valid = 1'b1; issue_waddr = 5'd5; issue_is_load = 1'b1; wb_valid = 1'b0;
      tick();
      issue_waddr = 5'd6;
      tick();
      issue_waddr = 5'd8; flush = 1'b1;
      tick();
      idle(); query_valid = 1'b1;
      for (int r = 5; r <= 8; r++) begin
         reg1_raddr = 5'(r); reg2_raddr = 5'(r);
         #1;
         total++;
         if (stall_id !== 1'b0 || stall_mem !== 1'b0) begin
            bad++; $display("FAIL flush_x%0d got=%b%b want=00", r, stall_id, stall_mem);
         end
      end
      total++;
      if (err_unf !== 1'b1) begin
         bad++; $display("FAIL flush_keeps_err got=%b want=1", err_unf);
      end
      do_reset();
      #1;
      total++;
      if (err_unf !== 1'b0 || err_ovf !== 1'b0) begin
         bad++; $display("FAIL reset_clears_err got=%b%b want=00", err_ovf, err_unf);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         rst_n         = ($urandom_range(0, 199) != 0);
         flush         = ($urandom_range(0, 49) == 0);
         issue_valid   = $urandom_range(0, 1);
         issue_waddr   = 5'($urandom_range(0, 5));
         issue_is_load = $urandom_range(0, 1);
         wb_valid      = $urandom_range(0, 1);
         wb_waddr      = 5'($urandom_range(0, 5));
         query_valid   = ($urandom_range(0, 3) != 0);
         reg1_raddr    = 5'($urandom_range(0, 6));
         reg2_raddr    = ($urandom_range(0, 3) == 0) ? reg1_raddr : 5'($urandom_range(0, 31));
         #1;
         total++;
         if (stall_id !== exp_stall_id() || stall_mem !== exp_stall_mem() ||
             issue_full !== exp_full() || err_ovf !== m_ovf || err_unf !== m_unf) begin
            bad++;
            $display("FAIL rand%0d got=%b%b%b%b%b want=%b%b%b%b%b", n, stall_id, stall_mem,
                     issue_full, err_ovf, err_unf, exp_stall_id(), exp_stall_mem(),
                     exp_full(), m_ovf, m_unf);
         end
         tick();
      end
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      for (int i = 0; i < 32; i++) begin
         m_cnt[i] = 0;
         m_ld[i]  = 0;
      end
      m_ovf = 0;
      m_unf = 0;
      @(posedge clk);
      #1;
      test_reset();
      test_basic();
      test_load();
      test_saturate();
      test_same_cycle();
      test_x0();
      test_flush();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
